alu_md: RTL and testbench
=========================

# alu_md

Parametrised next-generation execute-stage ALU for the MIPS pipeline: same single-cycle integer ops, a corrected arithmetic right shift and set-less-than, plus an iterative multiply/divide unit writing HI/LO registers. Single-cycle ops produce a combinational result on `c`. MULT/MULTU/DIV/DIVU run on a start/busy/done handshake that the hazard unit uses to stall.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH), shift-amount bits taken from `b`.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  WIDTH  signed operand A (rs).
- `b`  in  WIDTH  signed operand B (rt/immediate).
- `cmd`  in  4  operation select.
- `start`  in  1  launch multiply/divide when `cmd` is 12–15.
- `c`  out  WIDTH  combinational result of single-cycle ops.
- `hi`  out  WIDTH  HI register (product high half / remainder).
- `lo`  out  WIDTH  LO register (product low half / quotient).
- `busy`  out  1  multiply/divide in progress.
- `done`  out  1  one-cycle pulse: `hi`/`lo` just updated.

## Operation

- cmd codes:
  - 0 ADD, 2 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR, all wrap modulo 2^WIDTH.
  - 8 SLL `a << b[SHW-1:0]`.
  - 9 SRA (arithmetic, sign-filling).
  - 10 SRL (zero-filling).
  - 11 SLT: 1 if signed `a < b`, else 0.
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
  - 1, 3 → `c = 0`.
  - For cmd 12–15, `c = 0`.
- `c` is purely combinational and has no reset.
- FSM states:
  - IDLE: `busy=0`. `start=1` with cmd 12–15 latches `a`, `b`, op, clears the iteration counter, then goes to RUN. `start` with any other cmd is ignored.
  - RUN: `busy=1`. One iteration per cycle for WIDTH cycles (shift-add multiply / restoring divide on magnitudes). `start` is ignored. After the last iteration, sign-correct the result, write `hi`/`lo` and go to DONE.
  - DONE: `done=1`, `busy=0` for one cycle, then IDLE. A `start` in DONE is accepted exactly as in IDLE.
- Signed ops:
  - Operate on magnitudes and apply the sign at the end.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MULT yields the full 2·WIDTH signed product: `hi` = upper half, `lo` = lower half.
- Divide by zero (DIV or DIVU): `lo` = all ones, `hi` = `a`. Full latency still applies.
- DIV of most-negative by −1: `lo` = most-negative, `hi` = 0.
- `hi`/`lo` change only at the RUN→DONE edge or on reset. They hold their values otherwise.

## Timing

- Reset values: `hi=0`, `lo=0`, `busy=0`, `done=0`, state IDLE, counter 0.
- `rst` at any cycle, including mid-RUN, aborts the operation. Next cycle: reset values, no `done` pulse.
- `rst` wins over a simultaneous `start`.
- Latency, with `start` sampled at edge N:
  - `busy=1` in cycles N+1 … N+WIDTH.
  - `done=1` and new `hi`/`lo` visible in cycle N+WIDTH+1.
- Throughput: back-to-back ops possible by asserting `start` in the DONE cycle.
- Operands are captured at edge N. Changes to `a`/`b`/`cmd` afterwards do not affect the running op.
- `c` follows `a`, `b`, `cmd` combinationally in every state.

## Test plan

- WIDTH=32, single-cycle ops:
  - SRA 0x80000000 by 4 → `c`=0xF8000000.
  - SRL the same → 0x08000000.
  - SLT a=−1, b=1 → 1.
  - cmd=1 → 0.
  - ADD 0x7FFFFFFF+1 → 0x80000000.
- Multiply:
  - MULT a=−3, b=7: `busy` high for exactly 32 cycles, `done` pulse in cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Divide:
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 100/7 → `lo`=14, `hi`=2.
  - DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- Divide by zero: DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5, `done` in cycle 33.
- Handshake:
  - Second `start` (MULT 2×2) during RUN of a DIVU is ignored; only the DIVU result appears.
  - `start` asserted in the DONE cycle launches the next op with `done` 33 cycles later.
- Reset mid-op: MULT 3×3 completes (`hi`=0, `lo`=9). Then start DIVU, assert `rst` at cycle 10 of RUN → next cycle `busy=0`, `hi`=`lo`=0, and no `done` pulse within the following 40 cycles.

Source files
------------

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle integer ops on `c` plus an iterative
// multiply/divide unit (shift-add / restoring) that writes the HI/LO registers.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  input  logic             start,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic               op_div, op_uns;
  logic [WIDTH-1:0]   a_l, b_l, mb;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic               accept, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [SHW-1:0]     sh;

  assign sh = b[SHW-1:0];

  // NOTE: every path assigns c first via the default, so no latch is inferred.
  always_comb begin
    c = '0;
    case (cmd)
      4'd0:    c = a + b;
      4'd2:    c = a - b;
      4'd4:    c = a & b;
      4'd5:    c = a | b;
      4'd6:    c = ~(a | b);
      4'd7:    c = a ^ b;
      4'd8:    c = a << sh;
      4'd9:    c = $signed(a) >>> sh;
      4'd10:   c = a >> sh;
      4'd11:   c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: c = '0;
    endcase
  end

  // cmd 12..15: bit 1 selects divide, bit 0 selects unsigned.
  assign accept = start && (cmd[3:2] == 2'b11) && (state != S_RUN);
  assign last   = (state == S_RUN) && (cnt == SHW'(WIDTH - 1));
  assign mag_a  = (!cmd[0] && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (!cmd[0] && b[WIDTH-1]) ? -b : b;
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? S_RUN : S_IDLE;
      S_RUN:          state_nxt = last ? S_DONE : S_RUN;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // One iteration: shift-add multiply, or restoring divide with the
  // remainder in the upper half and the quotient shifting into the lower half.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
    div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = {1'b0, div_rs} - {2'b00, mb};
    if (!op_div)
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_diff[WIDTH+1])
      acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign correction and the divide-by-zero override, applied to the final iteration.
  logic               neg_a, neg_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  always_comb begin
    neg_a  = !op_uns && a_l[WIDTH-1];
    neg_b  = !op_uns && b_l[WIDTH-1];
    prod   = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    quo    = (neg_a ^ neg_b) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem    = neg_a ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_div) begin
      if (b_l == '0) begin
        res_hi = a_l;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else begin
      if (accept)               cnt <= '0;
      else if (state == S_RUN)  cnt <= cnt + 1'b1;
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  // NOTE: datapath working registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div <= cmd[1];
      op_uns <= cmd[0];
      a_l    <= a;
      b_l    <= b;
      mb     <= mag_b;
      acc    <= {{WIDTH{1'b0}}, mag_a};
    end else if (state == S_RUN) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: direct checks of `c`, and a HI/LO scoreboard
// whose expected results are popped by a monitor on every `done` pulse.
module tb_alu_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic [3:0]   cmd;
  logic [W-1:0] c, hi, lo;
  logic         busy, done;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] mexp;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cmd(cmd), .start(start),
    .c(c), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        mexp = sb.pop_front();
        check("sb_hi", hi, mexp[2*W-1:W]);
        check("sb_lo", lo, mexp[W-1:0]);
      end
    end
  end

  task automatic comb(input string name, input logic [3:0] op,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] exp);
    cmd = op; a = av; b = bv;
    #1;
    check(name, c, exp);
  endtask

  // Drives start for one edge from the current negedge; returns at the negedge of the first RUN cycle.
  task automatic launch(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit push);
    cmd = op; a = av; b = bv; start = 1'b1;
    if (push) sb.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles, output int done_at);
    busy_cycles = 0;
    done_at     = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    if (done_at == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected within 100 cycles");
    end
  endtask

  int bc, da, dcount;

  initial begin
    rst = 1'b1; start = 1'b0; cmd = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);

    comb("sra",      4'd9,  32'h8000_0000, 32'd4,        32'hF800_0000);
    comb("srl",      4'd10, 32'h8000_0000, 32'd4,        32'h0800_0000);
    comb("slt_true", 4'd11, 32'hFFFF_FFFF, 32'd1,        32'd1);
    comb("slt_false",4'd11, 32'd1,         32'hFFFF_FFFF,32'd0);
    comb("cmd1",     4'd1,  32'h1234_5678, 32'h1111_1111,32'd0);
    comb("add_wrap", 4'd0,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000);
    comb("sub",      4'd2,  32'd5,         32'd7,        32'hFFFF_FFFE);
    comb("nor",      4'd6,  32'hF0F0_0000, 32'h0000_0F0F,32'h0F0F_F0F0);
    comb("sll",      4'd8,  32'h0000_0003, 32'd30,       32'hC000_0000);
    comb("c_mult",   4'd12, 32'd3,         32'd3,        32'd0);

    @(negedge clk);
    launch(4'd12, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    wait_done(bc, da);
    check("mult_busy_cycles", W'(bc), 32'd32);
    check("mult_done_cycle",  W'(da), 32'd33);

    @(negedge clk);
    launch(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_done(bc, da);

    @(negedge clk);
    launch(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    wait_done(bc, da);

    // DIVU with a MULT start and operand churn mid-run; only DIVU may complete.
    @(negedge clk);
    launch(4'd15, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (3) @(negedge clk);
    cmd = 4'd12; a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, da);
    repeat (5) @(negedge clk);

    launch(4'd15, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_done(bc, da);
    check("div0_done_cycle", W'(da), 32'd33);

    // Back-to-back: start issued in the DONE cycle.
    launch(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    wait_done(bc, da);
    check("b2b_done_cycle", W'(da), 32'd33);

    @(negedge clk);
    launch(4'd12, 32'd3, 32'd3, 32'd0, 32'd9, 1'b1);
    wait_done(bc, da);

    @(negedge clk);
    launch(4'd15, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    check("hold_lo_midrun", lo, 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_hi",   hi, 32'h0);
    check("abort_lo",   lo, 32'h0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", W'(dcount), 32'd0);

    check("sb_empty", W'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
